reg_file_master: RTL

//  Initiator/sequencer for the 32x8 register file (write/read/addr/in/data port).

---
 rtl/reg_master_defs_pkg.sv | 23 ++
 rtl/rf_beat_cnt.sv | 34 +++
 rtl/reg_file_master.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/reg_master_defs_pkg.sv
// Shared definitions for the register-file master: default widths and FSM encodings.
// REG_MASTER_RMW_EN adds the RMW_RD state used by masked writes.
package reg_master_defs_pkg;

  localparam int DW     = 8;
  localparam int RF_AW  = 5;
  localparam int BUS_AW = 8;
  localparam int LEN_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_RD     = 3'd2,
    ST_RSP    = 3'd3,
`ifdef REG_MASTER_RMW_EN
    ST_ACK    = 3'd4,
    ST_RMW_RD = 3'd5
`else
    ST_ACK    = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/rf_beat_cnt.sv
// Burst position tracker: current register index (wraps modulo 2**RF_AW) and beats remaining.
// last is high while the current beat is the final one of the burst.
module rf_beat_cnt #(
  parameter int RF_AW = 5,
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [RF_AW-1:0] load_idx,
  input  logic [LEN_W-1:0] load_len,
  output logic [RF_AW-1:0] idx,
  output logic             last
);

  logic [LEN_W-1:0] rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      rem <= '0;
    end else if (load) begin
      idx <= load_idx;
      rem <= load_len;
    end else if (step) begin
      idx <= idx + 1'b1;
      rem <= rem - 1'b1;
    end
  end

  assign last = (rem == '0);

endmodule

// File: rtl/reg_file_master.sv
// Sequencer for the 32x8 register file: burst reads and fill writes behind a valid/ready request,
// read bytes / write ack returned on a valid/ready response. REG_MASTER_RMW_EN enables masked RMW writes.
module reg_file_master
  import reg_master_defs_pkg::*;
#(
  parameter int DW     = reg_master_defs_pkg::DW,
  parameter int RF_AW  = reg_master_defs_pkg::RF_AW,
  parameter int BUS_AW = reg_master_defs_pkg::BUS_AW,
  parameter int LEN_W  = reg_master_defs_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [RF_AW-1:0]  req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DW-1:0]     req_wdata,
  input  logic [DW-1:0]     req_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_data,
  output logic              rsp_last,
  output logic [BUS_AW-1:0] rf_addr,
  output logic [DW-1:0]     rf_in,
  output logic              rf_write,
  output logic              rf_read,
  input  logic [DW-1:0]     rf_data
);

  state_t           state, state_nxt;
  logic             cnt_load, cnt_step, cnt_last;
  logic [RF_AW-1:0] cnt_idx;
  logic [DW-1:0]    wdata_q, rsp_q, wr_byte;

  rf_beat_cnt #(.RF_AW(RF_AW), .LEN_W(LEN_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .step     (cnt_step),
    .load_idx (req_addr),
    .load_len (req_len),
    .idx      (cnt_idx),
    .last     (cnt_last)
  );

`ifdef REG_MASTER_RMW_EN
  logic [DW-1:0] mask_q, old_q;
  logic          rmw_need;

  assign rmw_need = (mask_q != {DW{1'b1}});
  assign wr_byte  = rmw_need ? ((old_q & ~mask_q) | (wdata_q & mask_q)) : wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      old_q  <= '0;
    end else begin
      if (state == ST_IDLE && req_valid) mask_q <= req_mask;
      if (state == ST_RMW_RD)            old_q  <= rf_data;
    end
  end
`else
  logic unused_mask;

  assign unused_mask = ^req_mask;
  assign wr_byte     = wdata_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      wdata_q <= '0;
      rsp_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && req_valid) wdata_q <= req_wdata;
      if (state == ST_RD)                rsp_q   <= rf_data;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_step  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          cnt_load = 1'b1;
          if (req_we) begin
`ifdef REG_MASTER_RMW_EN
            state_nxt = (req_mask != {DW{1'b1}}) ? ST_RMW_RD : ST_WR;
`else
            state_nxt = ST_WR;
`endif
          end else begin
            state_nxt = ST_RD;
          end
        end
      end
      ST_WR: begin
        if (cnt_last) begin
          state_nxt = ST_ACK;
        end else begin
          cnt_step  = 1'b1;
`ifdef REG_MASTER_RMW_EN
          state_nxt = rmw_need ? ST_RMW_RD : ST_WR;
`else
          state_nxt = ST_WR;
`endif
        end
      end
`ifdef REG_MASTER_RMW_EN
      ST_RMW_RD: state_nxt = ST_WR;
`endif
      ST_ACK: if (rsp_ready) state_nxt = ST_IDLE;
      ST_RD:  state_nxt = ST_RSP;
      ST_RSP: begin
        if (rsp_ready) begin
          if (cnt_last) begin
            state_nxt = ST_IDLE;
          end else begin
            cnt_step  = 1'b1;
            state_nxt = ST_RD;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset silences the file bus immediately.
  always_comb begin
    req_ready = (state == ST_IDLE);
    rf_write  = (state == ST_WR);
`ifdef REG_MASTER_RMW_EN
    rf_read   = (state == ST_RD) || (state == ST_RMW_RD);
`else
    rf_read   = (state == ST_RD);
`endif
    rf_addr   = (rf_write || rf_read) ? {{(BUS_AW-RF_AW){1'b0}}, cnt_idx} : '0;
    rf_in     = rf_write ? wr_byte : '0;
    rsp_valid = (state == ST_RSP) || (state == ST_ACK);
    rsp_last  = (state == ST_ACK) || ((state == ST_RSP) && cnt_last);
    rsp_data  = (state == ST_RSP) ? rsp_q : '0;
  end

endmodule
